// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and helpers for the instruction fetch queue.
//   ADDR_W / INSTR_W : fetch address and instruction widths
//   ifq_entry_t      : one queue entry {instr, pc, c}
//   fetch_state_t    : fetch FSM encodings IDLE / WAIT / DROP
//   OPC_JAL          : JAL major opcode
//   jal_offset()     : J-immediate, sign-extended and truncated to ADDR_W
package ifetch_pkg;

  localparam int ADDR_W  = 17;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic               c;
  } ifq_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [6:0] OPC_JAL = 7'b1101111;

  // Takes instr[31:12]; rebuilds imm[20:1] = {i[31], i[19:12], i[20], i[30:21]}.
  function automatic logic [ADDR_W-1:0] jal_offset(input logic [19:0] hi);
    logic signed [20:0] imm;
    imm = {hi[19], hi[7:0], hi[8], hi[18:9], 1'b0};
    return ADDR_W'(imm);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: circular instruction queue with combinational head read.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the queue; overrides enq/deq in the same cycle
//   enq        : write enq_data at tail (caller guarantees a free slot)
//   enq_data   : entry to write
//   deq        : advance head; ignored when empty
//   head_data  : entry at head (meaningless while count == 0)
//   count      : number of valid entries (0..2**DEPTH_LOG)
module ifq_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 enq,
  input  ifq_entry_t           enq_data,
  input  logic                 deq,
  output ifq_entry_t           head_data,
  output logic [DEPTH_LOG:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int CW    = DEPTH_LOG + 1;

  ifq_entry_t           mem [DEPTH];
  logic [DEPTH_LOG-1:0] head_q;
  logic [DEPTH_LOG-1:0] tail_q;
  logic [CW-1:0]        count_q;
  logic                 deq_ok;

  assign deq_ok = deq && (count_q != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq)    tail_q <= tail_q + DEPTH_LOG'(1);
      if (deq_ok) head_q <= head_q + DEPTH_LOG'(1);
      unique case ({enq, deq_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (enq && !flush) mem[tail_q] <= enq_data;
  end

  assign head_data = mem[head_q];
  assign count     = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch PC owner, single-outstanding icache requester and
// instruction queue feeding the decoder.
//   clk, rst         : clock, synchronous active-high reset
//   flush, flush_pc  : backend redirect; empties queue and reloads the PC
//   icache_req_en    : registered one-cycle fetch request
//   icache_req_addr  : fetch address, valid with icache_req_en
//   icache_out_en    : icache response strobe
//   icache_instr     : decompressed instruction
//   icache_c         : original instruction was 16-bit
//   deq_ready        : decoder takes the head entry
//   inst_valid       : queue non-empty
//   inst/inst_pc/inst_c : head entry
// Build option: define IFETCH_STATIC_JAL_EN to follow JAL targets at fetch.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int               DEPTH_LOG = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 17'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   flush_pc,
  output logic                icache_req_en,
  output logic [ADDR_W-1:0]   icache_req_addr,
  input  logic                icache_out_en,
  input  logic [INSTR_W-1:0]  icache_instr,
  input  logic                icache_c,
  input  logic                deq_ready,
  output logic                inst_valid,
  output logic [INSTR_W-1:0]  inst,
  output logic [ADDR_W-1:0]   inst_pc,
  output logic                inst_c
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int CW    = DEPTH_LOG + 1;

  fetch_state_t      state_q, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic [ADDR_W-1:0] seq_pc, next_pc;
  logic              req_n;
  logic              enq;
  logic [CW-1:0]     count;
  ifq_entry_t        enq_data, head_data;

  assign seq_pc = pc_q + (icache_c ? ADDR_W'(2) : ADDR_W'(4));

`ifdef IFETCH_STATIC_JAL_EN
  assign next_pc = (icache_instr[6:0] == OPC_JAL) ? pc_q + jal_offset(icache_instr[31:12])
                                                   : seq_pc;
`else
  assign next_pc = seq_pc;
`endif

  // A request can only leave IDLE, so the outstanding request is implied by
  // WAIT/DROP and count < DEPTH is enough to guarantee the reserved slot.
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    req_n   = 1'b0;
    enq     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush) begin
          pc_n = flush_pc;
        end else if (count < CW'(DEPTH)) begin
          req_n   = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          pc_n    = flush_pc;
          state_n = icache_out_en ? IDLE : DROP;
        end else if (icache_out_en) begin
          enq     = 1'b1;
          pc_n    = next_pc;
          state_n = IDLE;
        end
      end
      DROP: begin
        if (flush) pc_n = flush_pc;
        // A response arriving with a repeat flush still retires the request.
        if (icache_out_en) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      icache_req_en   <= 1'b0;
      icache_req_addr <= '0;
    end else begin
      state_q       <= state_n;
      pc_q          <= pc_n;
      icache_req_en <= req_n;
      if (req_n) icache_req_addr <= pc_q;
    end
  end

  assign enq_data = '{instr: icache_instr, pc: pc_q, c: icache_c};

  ifq_fifo #(
    .DEPTH_LOG (DEPTH_LOG)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq       (enq),
    .enq_data  (enq_data),
    .deq       (inst_valid && deq_ready),
    .head_data (head_data),
    .count     (count)
  );

  assign inst_valid = (count != '0);
  assign inst       = head_data.instr;
  assign inst_pc    = head_data.pc;
  assign inst_c     = head_data.c;

endmodule
